// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin owner of the shared memory port; each grant runs one block burst.
// Ports:
//   clock, reset                 rising-edge clock; asynchronous active-high reset
//   i_req/i_addr                 I-cache refill request and miss address
//   i_grant/i_rvalid/i_done      I ownership, per-beat read strobe, completion pulse
//   d_req/d_we/d_addr/d_wdata    D-cache refill or writeback request, per-beat write word
//   d_grant/d_rvalid/d_done      D ownership, per-beat read strobe, completion pulse
//   beat, rsp_data               current beat index; read word (mirrors mem_rdata)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   word-wide memory handshake
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS = 16,
    localparam int BW = $clog2(WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [BW-1:0]     beat,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int OFF = BW + 2;
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
    state_t state, state_nx;
    logic owner, we_lat, last_owner, win_d, busy, held;
    logic [ADDR_W-OFF-1:0] base_lat;
    logic unused_bits;
    assign unused_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};
    assign rsp_data = mem_rdata;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            we_lat     <= 1'b0;
            base_lat   <= '0;
            beat       <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && (i_req || d_req)) begin
                owner    <= win_d;
                we_lat   <= win_d & d_we;
                base_lat <= win_d ? d_addr[ADDR_W-1:OFF] : i_addr[ADDR_W-1:OFF];
                beat     <= '0;
            end
            // the last beat wraps the counter back to 0 on its own
            if (state == BURST && mem_ack) beat <= beat + 1'b1;
            if (state == DONE) last_owner <= owner;
        end
    end
    always_comb begin
        // on a tie the requester that did not own the previous burst wins
        win_d     = d_req & (~i_req | ~last_owner);
        state_nx  = state;
        busy      = state == BURST;
        held      = state != IDLE;
        i_grant   = held & ~owner;
        d_grant   = held & owner;
        mem_req   = busy;
        mem_we    = busy & we_lat;
        mem_addr  = busy ? {base_lat, beat, 2'b00} : '0;
        mem_wdata = (busy & we_lat) ? d_wdata : '0;
        i_rvalid  = busy & ~we_lat & mem_ack & ~owner;
        d_rvalid  = busy & ~we_lat & mem_ack & owner;
        i_done    = state == DONE & ~owner;
        d_done    = state == DONE & owner;
        case (state)
            IDLE:    state_nx = (i_req || d_req) ? BURST : IDLE;
            BURST:   state_nx = (mem_ack && beat == BW'(WORDS - 1)) ? DONE : BURST;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter with directed bursts.
module tb_cache_mem_arbiter;
    logic clock = 1'b0;
    logic reset;
    logic i_req, d_req, d_we, mem_ack, ack3;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata, rsp_data, mem_addr, mem_wdata;
    logic i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done, mem_req, mem_we;
    logic [3:0] beat;
    int total = 0;
    int bad = 0;
    typedef struct {
        int kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    always #5 clock = ~clock;
    function automatic logic [31:0] rd_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction
    assign mem_rdata = rd_f(mem_addr);
    assign d_wdata = 32'hA500_0000 + {28'd0, beat};
    cache_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_rvalid(d_rvalid), .d_done(d_done),
        .beat(beat), .rsp_data(rsp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // kinds: 0 I read beat, 1 D read beat, 2 D write beat, 3 I done, 4 D done
    task automatic push_beats(input int kind, input logic [31:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            e.kind = kind;
            e.addr = base + 32'(4 * j);
            e.data = (kind == 2) ? 32'hA500_0000 + 32'(j) : rd_f(e.addr);
            q.push_back(e);
        end
    endtask
    task automatic push_done(input int kind);
        exp_t e;
        e.kind = kind;
        e.addr = '0;
        e.data = '0;
        q.push_back(e);
    endtask
    task automatic push_burst(input int kind, input logic [31:0] base);
        push_beats(kind, base, 16);
        push_done(kind == 0 ? 3 : 4);
    endtask
    task automatic pop_chk(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h expected nothing", kind, a, d);
        end else begin
            e = q.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (e.kind < 3) begin
                chk("sb_addr", a, e.addr);
                chk("sb_data", d, e.data);
                chk("sb_beat", {28'd0, b}, {28'd0, e.addr[5:2]});
            end
        end
    endtask
    task automatic wait_done(input bit is_d);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(is_d ? d_done : i_done) && n < 300);
        chk(is_d ? "wait_d_done" : "wait_i_done", {31'd0, is_d ? d_done : i_done}, 32'd1);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask
    initial begin
        int cyc = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            mem_ack = ack3 ? (cyc % 3 == 0) : 1'b1;
        end
    end
    initial begin
        int k;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("inv_two_grants", {31'd0, i_grant & d_grant}, 32'd0);
                chk("inv_rvalid_write", {31'd0, (i_rvalid | d_rvalid) & mem_we}, 32'd0);
                chk("inv_rvalid_noack", {31'd0, (i_rvalid | d_rvalid) & ~(mem_req & mem_ack)}, 32'd0);
                if (mem_req && mem_ack) begin
                    k = i_rvalid ? 0 : d_rvalid ? 1 : mem_we ? 2 : 7;
                    pop_chk(k, mem_addr, mem_we ? mem_wdata : rsp_data, beat);
                end
                if (i_done) pop_chk(3, '0, '0, '0);
                if (d_done) pop_chk(4, '0, '0, '0);
            end
        end
    end
    initial begin
        int n, first_req, seen_d, rv;
        logic have_prev;
        logic [31:0] prev_addr;
        logic [3:0] prev_beat;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; ack3 = 0; reset = 1;
        repeat (2) @(negedge clock);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_grants", {30'd0, i_grant, d_grant}, 0);
        chk("rst_rvalid_done", {28'd0, i_rvalid, d_rvalid, i_done, d_done}, 0);
        chk("rst_beat", {28'd0, beat}, 0);
        chk("rst_rsp_data", rsp_data, rd_f(32'd0));
        reset = 0;
        @(negedge clock);
        // single I refill, zero wait states
        push_burst(0, 32'h1200);
        i_addr = 32'h0000_1234;
        i_req = 1;
        n = 1; first_req = 0; seen_d = 0;
        while (!i_done && n < 100) begin
            @(negedge clock);
            n++;
            if (mem_req && first_req == 0) first_req = n;
            if (d_grant) seen_d++;
        end
        chk("t1_first_req_cycle", 32'(first_req), 2);
        chk("t1_done_cycle", 32'(n), 18);
        chk("t1_no_d_grant", 32'(seen_d), 0);
        i_req = 0;
        // simultaneous requests alternate I, D, I, D
        do_reset();
        push_burst(0, 32'h3000);
        push_burst(1, 32'h5000);
        push_burst(0, 32'h3000);
        push_burst(1, 32'h5000);
        i_addr = 32'h3000; d_addr = 32'h5000; d_we = 0;
        i_req = 1; d_req = 1;
        wait_done(0);
        @(negedge clock);
        chk("t2_idle_gap", {31'd0, d_grant}, 0);
        @(negedge clock);
        chk("t2_d_granted", {31'd0, d_grant}, 1);
        wait_done(1);
        wait_done(0);
        wait_done(1);
        i_req = 0; d_req = 0;
        @(negedge clock);
        // D writeback
        push_burst(2, 32'h8040);
        d_addr = 32'h0000_8040; d_we = 1; d_req = 1;
        wait_done(1);
        d_req = 0; d_we = 0;
        @(negedge clock);
        // I refill with ack every third cycle
        ack3 = 1;
        push_burst(0, 32'h4000);
        i_addr = 32'h4000; i_req = 1;
        n = 0; rv = 0; have_prev = 0; prev_addr = 0; prev_beat = 0;
        while (!i_done && n < 400) begin
            @(negedge clock);
            n++;
            if (have_prev) begin
                chk("t4_hold_req", {31'd0, mem_req}, 1);
                chk("t4_hold_addr", mem_addr, prev_addr);
                chk("t4_hold_beat", {28'd0, beat}, {28'd0, prev_beat});
            end
            if (i_rvalid) rv++;
            have_prev = mem_req && !mem_ack;
            prev_addr = mem_addr;
            prev_beat = beat;
        end
        chk("t4_rvalid_count", 32'(rv), 16);
        i_req = 0; ack3 = 0;
        @(negedge clock);
        // reset during beat 7 of a D refill
        push_beats(1, 32'h2000, 8);
        d_addr = 32'h2000; d_we = 0; d_req = 1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(d_grant && beat == 4'd7) && n < 50);
        chk("t5_reach_beat7", {31'd0, d_grant && beat == 4'd7}, 1);
        #2;
        reset = 1; d_req = 0;
        #1;
        chk("t5_async_mem_req", {31'd0, mem_req}, 0);
        chk("t5_async_d_grant", {31'd0, d_grant}, 0);
        @(negedge clock);
        chk("t5_no_d_done", {31'd0, d_done}, 0);
        @(negedge clock);
        reset = 0;
        push_burst(0, 32'h7000);
        push_burst(1, 32'h7100);
        i_addr = 32'h7000; d_addr = 32'h7100; i_req = 1; d_req = 1;
        wait_done(0);
        i_req = 0;
        wait_done(1);
        d_req = 0;
        @(negedge clock);
        // I request dropped mid-burst
        push_burst(0, 32'h6000);
        i_addr = 32'h6000; i_req = 1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(i_grant && beat == 4'd3) && n < 50);
        chk("t6_reach_beat3", {31'd0, i_grant && beat == 4'd3}, 1);
        i_req = 0;
        wait_done(0);
        @(negedge clock);
        chk("t6_idle_no_grant", {30'd0, i_grant, d_grant}, 0);
        chk("t6_idle_no_req", {31'd0, mem_req}, 0);
        repeat (3) @(negedge clock);
        chk("sb_queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
